// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX arbiter state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } tx_arb_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request strictly after ptr, wrapping to 0.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant_onehot,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    // Indices above the pointer get first chance, then the wrapped range 0..ptr.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && (i > int'(ptr)) && req[i]) begin
        any             = 1'b1;
        grant_idx       = IW'(i);
        grant_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && (i <= int'(ptr)) && req[i]) begin
        any             = 1'b1;
        grant_idx       = IW'(i);
        grant_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters.
// Optional burst mode (several bytes per grant) is enabled by defining UART_TX_ARB_BURST_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = uart_pkg::DATA_W,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active
);

  import uart_pkg::*;

  localparam int IW = $clog2(NUM_REQ);

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (BURST_LEN < 1)) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and BURST_LEN >= 1");
  end

  tx_arb_state_e      state, state_nxt;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      arb_idx;
  logic [NUM_REQ-1:0] arb_onehot;
  logic               arb_any;
  logic               load_en;
  logic [IW-1:0]      load_sel;
  logic               release_en;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any          (arb_any)
  );

`ifdef UART_TX_ARB_BURST_EN
  localparam int CNT_W = ($clog2(BURST_LEN) > 3) ? $clog2(BURST_LEN) : 3;

  logic [CNT_W-1:0] burst_cnt;
  logic             burst_more;
  logic             burst_inc;

  assign burst_more = req_valid[grant_id] && (int'(burst_cnt) < (BURST_LEN - 1));
`endif

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    tx_start   = 1'b0;
    load_en    = 1'b0;
    load_sel   = arb_idx;
    release_en = 1'b0;
`ifdef UART_TX_ARB_BURST_EN
    burst_inc  = 1'b0;
`endif
    case (state)
      IDLE: begin
        // reset_n gate keeps a requester from seeing an accept while the block is held in reset.
        if (reset_n && arb_any && !tx_busy) begin
          req_ready = arb_onehot;
          load_en   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
`ifdef UART_TX_ARB_BURST_EN
          if (burst_more) begin
            req_ready[grant_id] = 1'b1;
            load_en             = 1'b1;
            load_sel            = grant_id;
            burst_inc           = 1'b1;
            state_nxt           = START;
          end else begin
            release_en = 1'b1;
            state_nxt  = IDLE;
          end
`else
          release_en = 1'b1;
          state_nxt  = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= IW'(NUM_REQ - 1);
      grant_id <= '0;
      tx_data  <= '0;
      active   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_en) begin
        tx_data  <= req_data[int'(load_sel)*DATA_W +: DATA_W];
        grant_id <= load_sel;
        active   <= 1'b1;
      end
      // The pointer only moves once the grant is fully released, so priority rotates per grant.
      if (release_en) begin
        rr_ptr <= grant_id;
        active <= 1'b0;
      end
    end
  end

`ifdef UART_TX_ARB_BURST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (burst_inc) begin
      burst_cnt <= burst_cnt + 1'b1;
    end else if (release_en) begin
      burst_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, BURST_LEN=4).
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_busy;
  logic                      tx_done;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic [1:0]                grant_id;
  logic                      active;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .BURST_LEN (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .active    (active)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-byte transaction from IDLE; req_valid is dropped once the byte is taken.
  task automatic do_grant(input int exp_id, input logic [7:0] exp_data, input string nm);
    logic [3:0] want;
    want = 4'b0001 << exp_id;
    #1;
    total++;
    if (req_ready !== want) begin
      bad++;
      $display("FAIL %s_accept: req_ready=%b expected %b", nm, req_ready, want);
    end
    tick();
    req_valid = '0;
    req_data  = ~req_data;
    #1;
    total++;
    if (tx_start !== 1'b1 || tx_data !== exp_data || grant_id !== 2'(exp_id) ||
        active !== 1'b1 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL %s_start: start=%b data=%h id=%0d active=%b ready=%b expected 1 %h %0d 1 0000",
               nm, tx_start, tx_data, grant_id, active, req_ready, exp_data, exp_id);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (tx_start !== 1'b0 || tx_data !== exp_data || active !== 1'b1 || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL %s_hold%0d: start=%b data=%h active=%b ready=%b expected 0 %h 1 0000",
                 nm, k, tx_start, tx_data, active, req_ready, exp_data);
      end
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
    total++;
    if (active !== 1'b0 || tx_start !== 1'b0 || grant_id !== 2'(exp_id)) begin
      bad++;
      $display("FAIL %s_release: active=%b start=%b id=%0d expected 0 0 %0d",
               nm, active, tx_start, grant_id, exp_id);
    end
  endtask

  // Holds vld, plays a transmitter (done two cycles after start) and checks the acceptance order.
  task automatic run_seq(input logic [3:0] vld, input int n, input int exp_ids [8], input string nm);
    int got = 0;
    int cd  = 0;
    logic [3:0] want;
    logic [7:0] want_data;
    req_valid = vld;
    for (int cyc = 0; cyc < 120 && got < n; cyc++) begin
      tx_done = (cd == 1);
      if (cd > 0) cd--;
      #1;
      if (req_ready !== 4'b0000) begin
        want = 4'b0001 << exp_ids[got];
        total++;
        if (req_ready !== want) begin
          bad++;
          $display("FAIL %s_order%0d: req_ready=%b expected %b", nm, got, req_ready, want);
        end
        got++;
      end
      if (tx_start === 1'b1) begin
        cd = 2;
        want_data = 8'h50 + 8'(exp_ids[got-1]);
        total++;
        if (tx_data !== want_data || grant_id !== 2'(exp_ids[got-1])) begin
          bad++;
          $display("FAIL %s_data%0d: tx_data=%h id=%0d expected %h %0d",
                   nm, got-1, tx_data, grant_id, want_data, exp_ids[got-1]);
        end
      end
      tick();
    end
    req_valid = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tx_done = (cd == 1);
      if (cd > 0) cd--;
      #1;
      if (tx_start === 1'b1) cd = 2;
      tick();
    end
    tx_done = 1'b0;
    total++;
    if (got != n || active !== 1'b0) begin
      bad++;
      $display("FAIL %s_count: accepted=%0d active=%b expected %0d 0", nm, got, active, n);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    req_data  = 32'h5352_5150;
    reset_n   = 1'b0;
    tick();
    tick();
    total++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0000 ||
        grant_id !== 2'd0 || active !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: start=%b data=%h ready=%b id=%0d active=%b expected all zero",
               tx_start, tx_data, req_ready, grant_id, active);
    end
    req_valid = '0;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic test_rr_order();
    int e [8];
`ifdef UART_TX_ARB_BURST_EN
    e = '{0, 0, 0, 0, 1, 0, 0, 0};
`else
    e = '{0, 1, 2, 3, 0, 0, 0, 0};
`endif
    apply_reset();
    req_data = 32'h5352_5150;
    run_seq(4'b1111, 5, e, "rr_order");
  endtask

  task automatic test_single();
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    do_grant(2, 8'hA5, "single_req2");
  endtask

  task automatic test_busy_block();
    req_data  = 32'h0000_003C;
    req_valid = 4'b0001;
    tx_busy   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (req_ready !== 4'b0000 || tx_start !== 1'b0 || active !== 1'b0) begin
        bad++;
        $display("FAIL busy_block%0d: ready=%b start=%b active=%b expected 0000 0 0",
                 k, req_ready, tx_start, active);
      end
      tick();
    end
    tx_busy = 1'b0;
    do_grant(0, 8'h3C, "busy_release");
  endtask

  task automatic test_done_coincident();
    req_data  = 32'h0000_2211;
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL coinc_first: req_ready=%b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    tx_done   = 1'b1;
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL coinc_same_cycle: req_ready=%b expected 0000", req_ready);
    end
    tick();
    tx_done = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL coinc_next_cycle: req_ready=%b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (tx_start !== 1'b1 || grant_id !== 2'd1 || tx_data !== 8'h22) begin
      bad++;
      $display("FAIL coinc_start: start=%b id=%0d data=%h expected 1 1 22", tx_start, grant_id, tx_data);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    req_data  = 32'h0000_8877;
    req_valid = 4'b0001;
    do_grant(0, 8'h77, "prereset_req0");
    req_data  = 32'h0000_8877;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    tick();
    total++;
    if (active !== 1'b1 || tx_data !== 8'h88 || grant_id !== 2'd1) begin
      bad++;
      $display("FAIL midreset_setup: active=%b data=%h id=%0d expected 1 88 1", active, tx_data, grant_id);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0000 ||
        grant_id !== 2'd0 || active !== 1'b0) begin
      bad++;
      $display("FAIL midreset_immediate: start=%b data=%h ready=%b id=%0d active=%b expected all zero",
               tx_start, tx_data, req_ready, grant_id, active);
    end
    tick();
    reset_n   = 1'b1;
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL midreset_priority: req_ready=%b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_burst_vs_rr();
    int e [8];
`ifdef UART_TX_ARB_BURST_EN
    e = '{1, 1, 1, 1, 3, 3, 3, 3};
`else
    e = '{1, 3, 1, 3, 1, 3, 1, 3};
`endif
    apply_reset();
    req_data = 32'h5352_5150;
    run_seq(4'b1010, 8, e, "burst_1_3");
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    test_reset();
    test_rr_order();
    test_single();
    test_busy_block();
    test_done_coincident();
    test_reset_mid_frame();
    test_burst_vs_rr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
